lsu_mem_adapter: RTL
====================

LSU_MEM_ADAPTER -- requirements
Module: lsu_mem_adapter

Interface
REQ-001 Parameter: none.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 req  input  1  access request, sampled only in IDLE.
REQ-005 we  input  1  1 = store, 0 = load; sampled with req.
REQ-006 funct3  input  3  access size: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-007 addr  input  32  byte address; sampled with req.
REQ-008 wdata  input  32  store data, low bytes used for b/h; sampled with req.
REQ-009 rdata  output  32  load result, extended per funct3.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 misalign  output  1  misaligned-access flag, valid with done.
REQ-013 mem_WE, mem_RE  output  1 each  data RAM write/read enables.
REQ-014 mem_A  output  32  data RAM byte address, always word-aligned ({addr[31:2],2'b00}).
REQ-015 mem_WD  output  32  data RAM write word, little-endian.
REQ-016 mem_RD  input  32  data RAM combinational read word.

Function
REQ-017 The block SHALL implement states IDLE, RD, WR, DONE.
REQ-018 In IDLE, req=1 SHALL latch we/funct3/addr/wdata and leave IDLE; req while busy SHALL be ignored.
REQ-019 Loads (any funct3) SHALL go IDLE->RD->DONE: RD drives mem_RE=1 and captures mem_RD at the rising edge that ends RD.
REQ-020 Store word SHALL go IDLE->WR->DONE: WR drives mem_WE=1, mem_WD=wdata.
REQ-021 Store byte/half SHALL go IDLE->RD->WR->DONE (read-modify-write): only the addressed byte(s) of the captured word are replaced; all other bytes are written back unchanged.
REQ-022 Byte lane = addr[1:0]; half lane = addr[1]; little-endian, with byte 0 at bits [7:0].
REQ-023 lb/lh SHALL sign-extend and lbu/lhu SHALL zero-extend the selected lane into rdata.
REQ-024 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 Latency from the req sample edge to the done cycle: load 2 cycles, sw 2 cycles, sb/sh 3 cycles.
REQ-026 rdata SHALL hold its value until the next load completes; stores SHALL NOT change rdata.
REQ-027 mem_WE and mem_RE SHALL be 0 in IDLE and DONE, and SHALL never both be 1.
REQ-028 Unlisted funct3 codes (011, 110, 111) SHALL skip memory, go directly to DONE with rdata=0, and leave RAM unmodified.
REQ-029 Misaligned means: h/hu with addr[0]=1, or w with addr[1:0]!=0.

Reset
REQ-030 When rst is asserted, the block SHALL asynchronously force IDLE, rdata=0, done=0, busy=0, misalign=0, mem_WE=0, mem_RE=0.
REQ-031 Reset during RD or WR SHALL abort the access; no write SHALL occur at any edge while rst=1.

Configuration
REQ-032 Macro MISALIGN_TRAP_EN defined: a misaligned access SHALL go IDLE->DONE with no RAM access, pulse misalign=1 with done, and leave rdata unchanged.
REQ-033 MISALIGN_TRAP_EN undefined: misalign SHALL be tied to 0; h ignores addr[0]; w ignores addr[1:0]; the access proceeds aligned-down.

Verification
REQ-034 RAM word0=0x00000001, word8=0x00000004: lw addr 0x8 -> done two cycles after req, rdata=0x00000004.
REQ-035 sb wdata 0x000000AB addr 0x5, then lw 0x4 (word4=0x00000001) -> rdata=0x0000AB01.
REQ-036 sh 0x8080 at 0x12, then lh 0x12 -> 0xFFFF8080; lhu 0x12 -> 0x00008080; lbu 0x13 -> 0x00000080.
REQ-037 lw addr 0x2 with MISALIGN_TRAP_EN -> misalign=1 with done one cycle after req, mem_RE never asserted; without the macro -> rdata=word0.
REQ-038 sb to 0x0, rst asserted during WR -> mem_WE falls immediately, busy=0, and a subsequent lw 0x0 returns 0x00000001.
REQ-039 req held high across a sb, with funct3 changed mid-access -> the in-flight access uses the latched values, and the next access starts the cycle after done.

Source files
------------

// File: rtl/lsu_mem_adapter.sv
// Load/store adapter between the LSU and a combinational data RAM.
// Optional: MISALIGN_TRAP_EN turns misaligned h/w accesses into trapped no-ops.
module lsu_mem_adapter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        misalign,
  output logic        mem_WE,
  output logic        mem_RE,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        f3_ok;
  logic        trap;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;
  logic [31:0] st_word;

  always_comb begin
    f3_ok = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010,
      3'b100, 3'b101: f3_ok = 1'b1;
      default:        f3_ok = 1'b0;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  assign trap = (funct3[1:0] == 2'b01 && addr[0])
             || (funct3 == 3'b010 && addr[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (!f3_ok || trap)           state_d = DONE;
          else if (!we)                 state_d = RD;
          else if (funct3[1:0] == 2'b10) state_d = WR;
          else                          state_d = RD;
        end
      end
      RD:      state_d = we_q ? WR : DONE;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ld_b = mem_RD[{addr_q[1:0], 3'b000} +: 8];
  assign ld_h = addr_q[1] ? mem_RD[31:16] : mem_RD[15:0];

  always_comb begin
    ld_ext = mem_RD;
    unique case (1'b1)
      (f3_q == 3'b000): ld_ext = {{24{ld_b[7]}}, ld_b};
      (f3_q == 3'b001): ld_ext = {{16{ld_h[15]}}, ld_h};
      (f3_q == 3'b100): ld_ext = {24'd0, ld_b};
      (f3_q == 3'b101): ld_ext = {16'd0, ld_h};
      default:          ld_ext = mem_RD;
    endcase
  end

  // Sub-word stores merge into the word captured during RD.
  always_comb begin
    st_word = word_q;
    unique case (1'b1)
      (f3_q[1:0] == 2'b00):
        st_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      (f3_q[1:0] == 2'b01):
        st_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: st_word = wdata_q;
    endcase
  end

  always_comb begin
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
`ifdef MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          f3_d    = funct3;
          addr_d  = addr;
          wdata_d = wdata;
          if (!f3_ok) rdata_d = 32'd0;
`ifdef MISALIGN_TRAP_EN
          mis_d   = f3_ok && trap;
`endif
        end
      end
      RD: begin
        word_d = mem_RD;
        if (!we_q) rdata_d = ld_ext;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
      rdata_q <= 32'd0;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  always_comb begin
    done     = (state_q == DONE);
    busy     = (state_q != IDLE);
    mem_RE   = (state_q == RD);
    mem_WE   = (state_q == WR);
    mem_A    = {addr_q[31:2], 2'b00};
    mem_WD   = st_word;
    rdata    = rdata_q;
`ifdef MISALIGN_TRAP_EN
    misalign = done && mis_q;
`else
    misalign = 1'b0;
`endif
  end

endmodule
